tick_scheduler: RTL and testbench

- Central timebase controller for the digital clock.
- Shares one system clock among all timed consumers and produces single-cycle enable strobes:
  - seconds tick for the time counters
  - 7-segment scan refresh tick, plus digit index
  - button debounce sample tick
- Sequences the seconds timebase through IDLE/RUN/SET modes, including a fast tick and display blink for time setting.
- Replaces per-consumer divided clocks: all downstream logic runs on clk and uses these enables.

---
 rtl/tick_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_tick_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Central timebase for the digital clock: derives single-cycle enable strobes
// (seconds, display refresh, debounce) from clk and sequences IDLE/RUN/SET modes.
module tick_scheduler #(
    parameter int SEC_DIV      = 100_000_000,
    parameter int FAST_DIV     = 10_000_000,
    parameter int BLINK_DIV    = 50_000_000,
    parameter int REFRESH_DIV  = 100_000,
    parameter int DEBOUNCE_DIV = 1_000_000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_i,
    input  logic       set_mode_i,
    input  logic       sync_i,
    output logic       sec_tick_o,
    output logic       refresh_tick_o,
    output logic       debounce_tick_o,
    output logic [1:0] scan_idx_o,
    output logic       blink_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SET  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] SEC_MAX   = CNT_W'(SEC_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_MAX  = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [CNT_W-1:0] REF_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // >= rather than == so a corrupted count above the limit still wraps
    function automatic logic at_limit(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] lim);
        return (cnt >= lim);
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             enter_set_s;
    logic             leave_set_s;
    logic [CNT_W-1:0] sec_lim_s;

    logic [CNT_W-1:0] sec_cnt_r;
    logic             sec_tick_r;
    logic [CNT_W-1:0] ref_cnt_r;
    logic             ref_tick_r;
    logic [1:0]       scan_idx_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic             deb_tick_r;
    logic [CNT_W-1:0] blink_cnt_r;
    logic             blink_r;

    // Next-state decode; set_mode_i overrides everything
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (set_mode_i)  state_next_s = ST_SET;
                else if (run_i)  state_next_s = ST_RUN;
                else             state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (set_mode_i)  state_next_s = ST_SET;
                else if (!run_i) state_next_s = ST_IDLE;
                else             state_next_s = ST_RUN;
            end
            ST_SET: begin
                if (set_mode_i)  state_next_s = ST_SET;
                else if (run_i)  state_next_s = ST_RUN;
                else             state_next_s = ST_IDLE;
            end
            default: begin
                if (set_mode_i)  state_next_s = ST_SET;
                else             state_next_s = ST_IDLE;
            end
        endcase
    end

    // SET boundary detection and the active seconds divider limit
    always_comb begin
        enter_set_s = (state_next_s == ST_SET) && (state_r != ST_SET);
        leave_set_s = (state_r == ST_SET) && (state_next_s != ST_SET);
        if (state_r == ST_SET) begin
            sec_lim_s = FAST_MAX;
        end else begin
            sec_lim_s = SEC_MAX;
        end
    end

    // Mode state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Seconds divider; sync and SET boundaries restart the phase without a tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_cnt_r  <= CNT_ZERO;
            sec_tick_r <= 1'b0;
        end else if (enter_set_s || leave_set_s || sync_i) begin
            sec_cnt_r  <= CNT_ZERO;
            sec_tick_r <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            sec_cnt_r  <= sec_cnt_r;
            sec_tick_r <= 1'b0;
        end else if (at_limit(sec_cnt_r, sec_lim_s)) begin
            sec_cnt_r  <= CNT_ZERO;
            sec_tick_r <= 1'b1;
        end else begin
            sec_cnt_r  <= sec_cnt_r + CNT_ONE;
            sec_tick_r <= 1'b0;
        end
    end

    // Free-running refresh divider and digit scan index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt_r  <= CNT_ZERO;
            ref_tick_r <= 1'b0;
            scan_idx_r <= 2'd0;
        end else if (at_limit(ref_cnt_r, REF_MAX)) begin
            ref_cnt_r  <= CNT_ZERO;
            ref_tick_r <= 1'b1;
            scan_idx_r <= scan_idx_r + 2'd1;
        end else begin
            ref_cnt_r  <= ref_cnt_r + CNT_ONE;
            ref_tick_r <= 1'b0;
            scan_idx_r <= scan_idx_r;
        end
    end

    // Free-running debounce sample divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt_r  <= CNT_ZERO;
            deb_tick_r <= 1'b0;
        end else if (at_limit(deb_cnt_r, DEB_MAX)) begin
            deb_cnt_r  <= CNT_ZERO;
            deb_tick_r <= 1'b1;
        end else begin
            deb_cnt_r  <= deb_cnt_r + CNT_ONE;
            deb_tick_r <= 1'b0;
        end
    end

    // Blink generator: restarts visible on SET entry, held visible outside SET
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_r <= CNT_ZERO;
            blink_r     <= 1'b1;
        end else if (enter_set_s) begin
            blink_cnt_r <= CNT_ZERO;
            blink_r     <= 1'b1;
        end else if ((state_r == ST_SET) && !leave_set_s) begin
            if (at_limit(blink_cnt_r, BLINK_MAX)) begin
                blink_cnt_r <= CNT_ZERO;
                blink_r     <= ~blink_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + CNT_ONE;
                blink_r     <= blink_r;
            end
        end else begin
            blink_cnt_r <= CNT_ZERO;
            blink_r     <= 1'b1;
        end
    end

    assign sec_tick_o      = sec_tick_r;
    assign refresh_tick_o  = ref_tick_r;
    assign debounce_tick_o = deb_tick_r;
    assign scan_idx_o      = scan_idx_r;
    assign blink_o         = blink_r;
    assign state_o         = state_r;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: per-cycle expected output vectors are
// queued as stimulus is driven and compared after the corresponding clock edge.
module tb_tick_scheduler;

    localparam int SEC_DIV      = 10;
    localparam int FAST_DIV     = 3;
    localparam int BLINK_DIV    = 5;
    localparam int REFRESH_DIV  = 4;
    localparam int DEBOUNCE_DIV = 6;
    localparam int CNT_W        = 4;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_SET  = 2'b10;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_i;
    logic       set_mode_i;
    logic       sync_i;
    logic       sec_tick_o;
    logic       refresh_tick_o;
    logic       debounce_tick_o;
    logic [1:0] scan_idx_o;
    logic       blink_o;
    logic [1:0] state_o;
    logic [7:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int rcyc     = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tick_scheduler #(
        .SEC_DIV(SEC_DIV), .FAST_DIV(FAST_DIV), .BLINK_DIV(BLINK_DIV),
        .REFRESH_DIV(REFRESH_DIV), .DEBOUNCE_DIV(DEBOUNCE_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .run_i(run_i), .set_mode_i(set_mode_i),
        .sync_i(sync_i), .sec_tick_o(sec_tick_o), .refresh_tick_o(refresh_tick_o),
        .debounce_tick_o(debounce_tick_o), .scan_idx_o(scan_idx_o),
        .blink_o(blink_o), .state_o(state_o)
    );

    assign obs = {sec_tick_o, refresh_tick_o, debounce_tick_o, scan_idx_o, blink_o, state_o};

    // Expected output vector; free-running strobes derive from edges since reset release
    function automatic logic [7:0] expect_vec(input logic sec, input int rc,
                                              input logic blink, input logic [1:0] st);
        logic       refr;
        logic       deb;
        logic [1:0] scan;
        refr = (rc != 0) && ((rc % REFRESH_DIV) == 0);
        deb  = (rc != 0) && ((rc % DEBOUNCE_DIV) == 0);
        scan = 2'((rc / REFRESH_DIV) % 4);
        return {sec, refr, deb, scan, blink, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) rcyc++;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(expect_vec(1'b0, 0, 1'b1, S_IDLE));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%b exp=%b", i, obs, e);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_free_run();
        logic [7:0] e;
        for (int i = 0; i < 24; i++) begin
            exp_q.push_back(expect_vec(1'b0, rcyc + 1, 1'b1, S_IDLE));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL free_run i=%0d got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    task automatic test_run();
        logic [7:0] e;
        run_i = 1'b1;
        for (int j = 0; j < 27; j++) begin
            exp_q.push_back(expect_vec((j > 0) && (j % SEC_DIV == 0), rcyc + 1, 1'b1, S_RUN));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL run j=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    // Count is 6 here; the last RUN edge brings it to 7, then IDLE holds it
    task automatic test_pause();
        logic [7:0] e;
        for (int j = 27; j < 40; j++) begin
            run_i = (j >= 32);
            exp_q.push_back(expect_vec(j == 35, rcyc + 1, 1'b1, (j >= 32) ? S_RUN : S_IDLE));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pause j=%0d got=%b exp=%b", j, obs, e);
            end
        end
    endtask

    task automatic test_set_mode();
        logic [7:0] e;
        set_mode_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(expect_vec((k > 0) && (k % FAST_DIV == 0), rcyc + 1,
                                       ((k / BLINK_DIV) % 2) == 0, S_SET));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL set k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        set_mode_i = 1'b0;
        for (int m = 0; m < 13; m++) begin
            exp_q.push_back(expect_vec(m == 10, rcyc + 1, 1'b1, S_RUN));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL set_release m=%0d got=%b exp=%b", m, obs, e);
            end
        end
    endtask

    // Sync lands on the edge that would wrap (m=20); next tick is 10 edges later
    task automatic test_sync();
        logic [7:0] e;
        for (int m = 13; m < 32; m++) begin
            sync_i = (m == 20);
            exp_q.push_back(expect_vec(m == 30, rcyc + 1, 1'b1, S_RUN));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL sync m=%0d got=%b exp=%b", m, obs, e);
            end
        end
        sync_i = 1'b0;
    endtask

    // Held count 2 in IDLE is cleared by sync, so RUN needs a full 10 edges
    task automatic test_sync_idle();
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            run_i  = (i >= 4);
            sync_i = (i == 2);
            exp_q.push_back(expect_vec(i == 14, rcyc + 1, 1'b1, (i >= 4) ? S_RUN : S_IDLE));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL sync_idle i=%0d got=%b exp=%b", i, obs, e);
            end
        end
        sync_i = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        #2;
        reset = 1'b0;
        rcyc  = 0;
        exp_q.push_back(expect_vec(1'b0, 0, 1'b1, S_IDLE));
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL async_reset_immediate got=%b exp=%b", obs, e);
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(expect_vec(1'b0, 0, 1'b1, S_IDLE));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL async_reset_hold i=%0d got=%b exp=%b", i, obs, e);
            end
        end
        run_i = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(expect_vec(1'b0, rcyc + 1, 1'b1, S_IDLE));
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL after_reset i=%0d got=%b exp=%b", i, obs, e);
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        run_i      = 1'b0;
        set_mode_i = 1'b0;
        sync_i     = 1'b0;
        test_reset();
        test_free_run();
        test_run();
        test_pause();
        test_set_mode();
        test_sync();
        test_sync_idle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
